// File: rtl/mem_pkg.sv
// mem_pkg: shared types and widths for the memory responder
package mem_pkg;
    localparam int MEM_DATA_W      = 16;
    localparam int MEM_ADDR_BUS_W  = 16;
    localparam int DEFAULT_LATENCY = 4;
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: word storage, synchronous write with load-port priority, asynchronous read
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                      clk,
    input  logic                      load_en,
    input  logic [MEM_ADDR_BUS_W-1:0] load_addr,
    input  logic [MEM_DATA_W-1:0]     load_data,
    input  logic                      we,
    input  logic [MEM_ADDR_BUS_W-1:0] waddr,
    input  logic [MEM_DATA_W-1:0]     wdata,
    input  logic [MEM_ADDR_BUS_W-1:0] raddr,
    output logic [MEM_DATA_W-1:0]     rdata
);
    logic [MEM_DATA_W-1:0] mem [2**ADDR_W];

    // contents are never reset; the preload port wins over the processor write
    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr[ADDR_W-1:0]] <= load_data;
        else if (we) mem[waddr[ADDR_W-1:0]] <= wdata;
    end

    assign rdata = mem[raddr[ADDR_W-1:0]];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency read responder with write forwarding; MEM_RESPONDER_STATS_EN adds rd/wr counters
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MEM_ADDR_BUS_W-1:0] mem_read_addr,
    output logic [MEM_DATA_W-1:0]     mem_read_data,
    output logic                      mem_read_ack,
    input  logic                      mem_we,
    input  logic [MEM_ADDR_BUS_W-1:0] mem_write_addr,
    input  logic [MEM_DATA_W-1:0]     mem_write_data,
    input  logic                      load_en,
    input  logic [MEM_ADDR_BUS_W-1:0] load_addr,
`ifdef MEM_RESPONDER_STATS_EN
    input  logic [MEM_DATA_W-1:0]     load_data,
    output logic [31:0]               rd_count,
    output logic [31:0]               wr_count
`else
    input  logic [MEM_DATA_W-1:0]     load_data
`endif
);
    state_t                    state, state_n;
    logic [3:0]                cnt, cnt_n;
    logic [MEM_ADDR_BUS_W-1:0] cap_addr, cap_n;
    logic                      cap_valid, val_n;
    logic [MEM_DATA_W-1:0]     data_n, arr_data, fwd_data;
    logic                      ack_n, chg, wr_en;
    logic [MEM_ADDR_BUS_W-1:0] wr_addr;
    logic [MEM_DATA_W-1:0]     wr_data;

    mem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk      (clk),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .we       (mem_we),
        .waddr    (mem_write_addr),
        .wdata    (mem_write_data),
        .raddr    (cap_addr),
        .rdata    (arr_data)
    );

    assign wr_en    = load_en | mem_we;
    assign wr_addr  = load_en ? load_addr : mem_write_addr;
    assign wr_data  = load_en ? load_data : mem_write_data;
    assign fwd_data = (wr_en && wr_addr[ADDR_W-1:0] == cap_addr[ADDR_W-1:0]) ? wr_data : arr_data;
    assign chg      = !cap_valid || mem_read_addr != cap_addr;

    // an address change always restarts the countdown; otherwise WAIT counts down to the ack
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cap_n   = cap_addr;
        val_n   = cap_valid;
        data_n  = mem_read_data;
        ack_n   = 1'b0;
        if (chg) begin
            state_n = WAIT;
            cnt_n   = 4'(LATENCY - 1);
            cap_n   = mem_read_addr;
            val_n   = 1'b1;
        end else if (state == WAIT) begin
            if (cnt == 4'd0) begin
                data_n  = fwd_data;
                ack_n   = 1'b1;
                state_n = HOLD;
            end else begin
                cnt_n = cnt - 4'd1;
            end
        end
    end

    // FSM, countdown, captured address and registered read outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            cap_addr      <= '0;
            cap_valid     <= 1'b0;
            mem_read_data <= '0;
            mem_read_ack  <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            cap_addr      <= cap_n;
            cap_valid     <= val_n;
            mem_read_data <= data_n;
            mem_read_ack  <= ack_n;
        end
    end

`ifdef MEM_RESPONDER_STATS_EN
    // saturating counters: acks issued and processor writes that actually commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (ack_n && rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
            if (mem_we && !load_en && wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (LATENCY=4, ADDR_W=10)
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_read_addr, mem_write_addr, mem_write_data, load_addr, load_data;
    logic [15:0] mem_read_data;
    logic        mem_read_ack, mem_we, load_en;
`ifdef MEM_RESPONDER_STATS_EN
    logic [31:0] rd_count, wr_count;
`endif

    typedef struct {logic [15:0] d; int c;} exp_t;
    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   acks = 0;

    mem_responder #(.ADDR_W(10), .LATENCY(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read_addr (mem_read_addr),
        .mem_read_data (mem_read_data),
        .mem_read_ack  (mem_read_ack),
        .mem_we        (mem_we),
        .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data),
        .load_en       (load_en),
        .load_addr     (load_addr),
`ifdef MEM_RESPONDER_STATS_EN
        .load_data     (load_data),
        .rd_count      (rd_count),
        .wr_count      (wr_count)
`else
        .load_data     (load_data)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_read(input logic [15:0] d);
        exp_t e;
        e.d = d;
        e.c = cyc + 1 + 4;
        q.push_back(e);
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
    endtask

    // monitor: every ack must match the head of the scoreboard in data and cycle
    always @(posedge clk) begin
        #1;
        if (mem_read_ack === 1'b1) begin
            acks++;
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_ack: got data %h at cycle %0d, no read outstanding", mem_read_data, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ack_data", 32'(mem_read_data), 32'(e.d));
                chk("ack_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mem_read_addr = '0;
        mem_we = 1'b0;
        mem_write_addr = '0;
        mem_write_data = '0;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        preload(16'd0, 16'h0105);
        preload(16'd2, 16'h2222);
        preload(16'd5, 16'h5555);
        preload(16'd6, 16'hBEEF);
        preload(16'd7, 16'h7777);
        preload(16'd9, 16'h0909);
        @(negedge clk);
        load_en = 1'b0;
        chk("reset_data", 32'(mem_read_data), 32'h0);
        chk("reset_ack", 32'(mem_read_ack), 32'h0);
        // first read straight out of reset
        @(negedge clk);
        rst = 1'b0;
        expect_read(16'h0105);
        repeat (4) @(negedge clk);
        chk("data_before_first_ack", 32'(mem_read_data), 32'h0);
        repeat (2) @(negedge clk);
        // address 5 abandoned after two cycles in favour of 6
        mem_read_addr = 16'd5;
        repeat (2) @(negedge clk);
        mem_read_addr = 16'd6;
        expect_read(16'hBEEF);
        repeat (6) @(negedge clk);
        chk("hold_data", 32'(mem_read_data), 32'hBEEF);
        // write forwarded on the completion edge
        mem_read_addr = 16'd7;
        expect_read(16'h1234);
        repeat (4) @(negedge clk);
        mem_we = 1'b1;
        mem_write_addr = 16'd7;
        mem_write_data = 16'h1234;
        @(negedge clk);
        mem_we = 1'b0;
        repeat (2) @(negedge clk);
        // aliased write during WAIT becomes visible in the read
        mem_read_addr = 16'd9;
        expect_read(16'h9999);
        repeat (2) @(negedge clk);
        mem_we = 1'b1;
        mem_write_addr = 16'h0409;
        mem_write_data = 16'h9999;
        @(negedge clk);
        mem_we = 1'b0;
        repeat (4) @(negedge clk);
        // upper address bits ignored
        mem_read_addr = 16'h0402;
        expect_read(16'h2222);
        repeat (6) @(negedge clk);
        chk("alias_hold", 32'(mem_read_data), 32'h2222);
`ifdef MEM_RESPONDER_STATS_EN
        chk("rd_count", rd_count, 32'd5);
        chk("wr_count", wr_count, 32'd2);
`endif
        // reset in WAIT abandons the read; a fresh read follows release
        mem_read_addr = 16'd5;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_wait_data", 32'(mem_read_data), 32'h0);
        chk("rst_wait_ack", 32'(mem_read_ack), 32'h0);
`ifdef MEM_RESPONDER_STATS_EN
        chk("rd_count_reset", rd_count, 32'd0);
        chk("wr_count_reset", wr_count, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        expect_read(16'h5555);
        repeat (4) @(negedge clk);
        chk("data_zero_after_rst", 32'(mem_read_data), 32'h0);
        repeat (8) @(negedge clk);
        chk("final_hold", 32'(mem_read_data), 32'h5555);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("ack_total", 32'(acks), 32'd6);
`ifdef MEM_RESPONDER_STATS_EN
        chk("rd_count_end", rd_count, 32'd1);
        chk("wr_count_end", wr_count, 32'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
